// File: rtl/bht_predictor_pkg.sv
// Shared constants for the branch-history-table predictor: opcodes, counter
// threshold/init helpers and the init/run state encoding.
package bht_predictor_pkg;

  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_e;

  // Counter value at or above which a branch is predicted taken.
  function automatic int cnt_thresh(input int cnt_bit);
    return 1 << (cnt_bit - 1);
  endfunction

  // Weakly-not-taken: one below the taken threshold.
  function automatic int cnt_init(input int cnt_bit);
    return (1 << (cnt_bit - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_ghr.sv
// Global history register: shifts in each predicted branch outcome and can be
// restored from a checkpoint on mispredict (restore wins over shift).
module bp_ghr #(
  parameter int HIST_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                shift_en,
  input  logic                shift_bit,
  input  logic                restore_en,
  input  logic [HIST_LEN-1:0] restore_hist,
  input  logic                restore_bit,
  output logic [HIST_LEN-1:0] ghr
);

  // Concatenate then drop the MSB so HIST_LEN = 1 needs no special case.
  logic [HIST_LEN:0] shift_cat;
  logic [HIST_LEN:0] restore_cat;
  logic              unused_msb;

  assign shift_cat   = {ghr, shift_bit};
  assign restore_cat = {restore_hist, restore_bit};
  assign unused_msb  = shift_cat[HIST_LEN] ^ restore_cat[HIST_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (rdy) begin
      if (restore_en) begin
        ghr <= restore_cat[HIST_LEN-1:0];
      end else if (shift_en) begin
        ghr <= shift_cat[HIST_LEN-1:0];
      end
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Saturating-counter branch history table with an init sweep after reset.
// Define BHT_GSHARE_EN for gshare indexing (PC xor global history).
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int CNT_BIT  = 2,
  parameter int BHT_SIZE = 256,
  parameter int HIST_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                pd_valid,
  input  logic [31:0]         pd_pc,
  input  logic [31:0]         pd_inst,
  output logic                pd_ready,
  output logic                pd_taken,
  output logic [31:0]         pd_off,
  output logic [HIST_LEN-1:0] pd_hist,
  input  logic                fb_ena,
  input  logic [31:0]         fb_pc,
  input  logic [HIST_LEN-1:0] fb_hist,
  input  logic                fb_taken,
  input  logic                fb_mispred,
  output bht_state_e          dbg_state
);

  localparam int IDX_W = $clog2(BHT_SIZE);
  localparam logic [CNT_BIT-1:0] CNT_MAX = '1;
  localparam logic [CNT_BIT-1:0] CNT_THR = CNT_BIT'(cnt_thresh(CNT_BIT));
  localparam logic [CNT_BIT-1:0] CNT_INI = CNT_BIT'(cnt_init(CNT_BIT));

  bht_state_e                state;
  logic [IDX_W-1:0]          init_ptr;
  logic [CNT_BIT-1:0]        bht_mem [BHT_SIZE];
  logic [HIST_LEN-1:0]       ghr;
  logic [IDX_W-1:0]          pd_idx;
  logic [IDX_W-1:0]          fb_idx;
  logic [CNT_BIT-1:0]        pd_cnt;
  logic [CNT_BIT-1:0]        fb_cnt;
  logic [CNT_BIT-1:0]        fb_next;
  logic                      is_br;
  logic                      is_jal;
  logic [31:0]               imm_b;
  logic [31:0]               imm_j;

  assign is_br  = (pd_inst[6:0] == OPC_BR);
  assign is_jal = (pd_inst[6:0] == OPC_JAL);
  assign imm_b  = {{19{pd_inst[31]}}, pd_inst[31], pd_inst[7], pd_inst[30:25],
                   pd_inst[11:8], 1'b0};
  assign imm_j  = {{11{pd_inst[31]}}, pd_inst[31], pd_inst[19:12], pd_inst[20],
                   pd_inst[30:21], 1'b0};

`ifdef BHT_GSHARE_EN
  assign pd_idx = pd_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign fb_idx = fb_pc[IDX_W+1:2] ^ IDX_W'(fb_hist);

  bp_ghr #(.HIST_LEN(HIST_LEN)) u_ghr (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .shift_en     (pd_ready & pd_valid & is_br),
    .shift_bit    (pd_taken),
    .restore_en   (pd_ready & fb_ena & fb_mispred),
    .restore_hist (fb_hist),
    .restore_bit  (fb_taken),
    .ghr          (ghr)
  );

  logic unused_pc;
  assign unused_pc = ^{pd_pc[1:0], pd_pc[31:IDX_W+2], fb_pc[1:0], fb_pc[31:IDX_W+2]};
`else
  assign pd_idx = pd_pc[IDX_W+1:2];
  assign fb_idx = fb_pc[IDX_W+1:2];
  assign ghr    = '0;

  logic unused_pc;
  assign unused_pc = ^{pd_pc[1:0], pd_pc[31:IDX_W+2], fb_pc[1:0], fb_pc[31:IDX_W+2],
                       pd_valid, fb_hist, fb_mispred};
`endif

  // Reads are taken before any same-cycle update lands (no bypass).
  assign pd_cnt = bht_mem[pd_idx];
  assign fb_cnt = bht_mem[fb_idx];

  always_comb begin
    fb_next = fb_cnt;
    if (fb_taken) begin
      if (fb_cnt != CNT_MAX) fb_next = fb_cnt + CNT_BIT'(1);
    end else begin
      if (fb_cnt != '0) fb_next = fb_cnt - CNT_BIT'(1);
    end
  end

  // Handshake: a request is consumed on any rdy edge where pd_valid and
  // pd_ready are both high; pd_ready stays high for the whole RUN state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      pd_ready <= 1'b0;
    end else if (rdy) begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + IDX_W'(1);
          if (init_ptr == IDX_W'(BHT_SIZE - 1)) begin
            state    <= ST_RUN;
            pd_ready <= 1'b1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (state == ST_INIT) begin
        bht_mem[init_ptr] <= CNT_INI;
      end else if (pd_ready && fb_ena) begin
        bht_mem[fb_idx] <= fb_next;
      end
    end
  end

  always_comb begin
    pd_taken = 1'b0;
    if (pd_ready) begin
      if (is_br)       pd_taken = (pd_cnt >= CNT_THR);
      else if (is_jal) pd_taken = 1'b1;
    end
  end

  assign pd_off    = is_br ? imm_b : (is_jal ? imm_j : 32'h0);
  assign pd_hist   = ghr;
  assign dbg_state = state;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor (default parameters); the history section
// follows whichever build (BHT_GSHARE_EN defined or not) is compiled.
module tb_bht_predictor;
  import bht_predictor_pkg::*;

  localparam int HL = 8;
  localparam logic [31:0] INST_BR   = 32'hFE000EE3;
  localparam logic [31:0] INST_JAL  = 32'h0080006F;
  localparam logic [31:0] INST_ADDI = 32'h00100093;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          pd_valid;
  logic [31:0]   pd_pc;
  logic [31:0]   pd_inst;
  logic          pd_ready;
  logic          pd_taken;
  logic [31:0]   pd_off;
  logic [HL-1:0] pd_hist;
  logic          fb_ena;
  logic [31:0]   fb_pc;
  logic [HL-1:0] fb_hist;
  logic          fb_taken;
  logic          fb_mispred;
  bht_state_e    dbg_state;

  int errors = 0;
  int checks = 0;
  int n_cyc;

  bht_predictor dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .pd_valid   (pd_valid),
    .pd_pc      (pd_pc),
    .pd_inst    (pd_inst),
    .pd_ready   (pd_ready),
    .pd_taken   (pd_taken),
    .pd_off     (pd_off),
    .pd_hist    (pd_hist),
    .fb_ena     (fb_ena),
    .fb_pc      (fb_pc),
    .fb_hist    (fb_hist),
    .fb_taken   (fb_taken),
    .fb_mispred (fb_mispred),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts rdy edges until pd_ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (pd_ready !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic fb_pulse(input logic [31:0] pc, input logic [HL-1:0] hist,
                          input logic tk, input logic mp);
    fb_ena     = 1'b1;
    fb_pc      = pc;
    fb_hist    = hist;
    fb_taken   = tk;
    fb_mispred = mp;
    @(posedge clk);
    #1;
    fb_ena     = 1'b0;
    fb_mispred = 1'b0;
  endtask

  task automatic predict(input logic [31:0] pc, input logic [31:0] inst);
    pd_pc   = pc;
    pd_inst = inst;
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pd_valid = 1'b0; pd_pc = 32'h100; pd_inst = INST_BR;
    fb_ena = 1'b0; fb_pc = 32'h0; fb_hist = '0; fb_taken = 1'b0; fb_mispred = 1'b0;

    // reset state, then a reset mid-INIT restarts the sweep
    #12;
    check("rst_ready", pd_ready, 1'b0);
    check("rst_state", dbg_state, ST_INIT);
    check("rst_hist", pd_hist, '0);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("init_mid_ready", pd_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("init_rst_state", dbg_state, ST_INIT);
    rst = 1'b0;
    wait_ready(n_cyc);
    check("init_len", n_cyc, 256);
    check("run_state", dbg_state, ST_RUN);

    // first cycle after init: weakly-not-taken
    predict(32'h100, INST_BR);
    check("br_init_taken", pd_taken, 1'b0);
    check("br_off", pd_off, 32'hFFFFFFFC);

    predict(32'h100, INST_JAL);
    check("jal_taken", pd_taken, 1'b1);
    check("jal_off", pd_off, 32'h8);
    predict(32'h100, INST_ADDI);
    check("addi_taken", pd_taken, 1'b0);
    check("addi_off", pd_off, 32'h0);

    // counter training at pc 0x100 (ghr stays 0)
    predict(32'h100, INST_BR);
    fb_pulse(32'h100, '0, 1'b1, 1'b0);
    #1 check("cnt2_taken", pd_taken, 1'b1);
    fb_pulse(32'h100, '0, 1'b1, 1'b0);
    #1 check("cnt3_taken", pd_taken, 1'b1);
    fb_pulse(32'h100, '0, 1'b0, 1'b0);
    fb_pulse(32'h100, '0, 1'b0, 1'b0);
    #1 check("cnt1_taken", pd_taken, 1'b0);
    fb_pulse(32'h100, '0, 1'b0, 1'b0);
    #1 check("cnt0_taken", pd_taken, 1'b0);

    // same-cycle read sees the pre-update value; 0 -> 1 stays not-taken
    fb_ena = 1'b1; fb_pc = 32'h100; fb_hist = '0; fb_taken = 1'b1;
    #1 check("no_bypass", pd_taken, 1'b0);
    @(posedge clk);
    #1 fb_ena = 1'b0;
    check("cnt0to1_taken", pd_taken, 1'b0);

    // saturation at 0 and at max
    fb_pulse(32'h100, '0, 1'b0, 1'b0);
    fb_pulse(32'h100, '0, 1'b0, 1'b0);
    fb_pulse(32'h100, '0, 1'b1, 1'b0);
    #1 check("sat_low", pd_taken, 1'b0);
    fb_pulse(32'h100, '0, 1'b1, 1'b0);
    fb_pulse(32'h100, '0, 1'b1, 1'b0);
    fb_pulse(32'h100, '0, 1'b1, 1'b0);
    fb_pulse(32'h100, '0, 1'b0, 1'b0);
    #1 check("sat_high", pd_taken, 1'b1);

    // indexing: neighbour entry untouched, aliasing pc shares the entry
    predict(32'h104, INST_BR);
    check("idx_neighbour", pd_taken, 1'b0);
    predict(32'h500, INST_BR);
    check("idx_alias", pd_taken, 1'b1);

    // rdy low: nothing changes
    rdy = 1'b0;
    pd_valid = 1'b1; pd_pc = 32'h200; pd_inst = INST_BR;
    fb_ena = 1'b1; fb_pc = 32'h200; fb_hist = '1; fb_taken = 1'b1; fb_mispred = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pd_valid = 1'b0; fb_ena = 1'b0; fb_mispred = 1'b0; fb_hist = '0;
    rdy = 1'b1;
    predict(32'h200, INST_BR);
    check("stall_cnt", pd_taken, 1'b0);
    check("stall_hist", pd_hist, '0);
    predict(32'h100, INST_BR);
    check("stall_keep", pd_taken, 1'b1);

    // reset mid-RUN: immediate drop, sweep restarts (and stalls with rdy low)
    rst = 1'b1;
    #1;
    check("run_rst_ready", pd_ready, 1'b0);
    check("run_rst_state", dbg_state, ST_INIT);
    rdy = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("init_stall", pd_ready, 1'b0);
    rdy = 1'b1;
    wait_ready(n_cyc);
    check("reinit_len", n_cyc, 256);
    predict(32'h100, INST_BR);
    check("reinit_cnt", pd_taken, 1'b0);

`ifdef BHT_GSHARE_EN
    // restore from checkpoint, then restore beats a same-cycle shift
    fb_pulse(32'h800, 8'h02, 1'b1, 1'b1);
    check("ghr_restore", pd_hist, 8'h05);
    fb_pulse(32'h100, 8'h05, 1'b1, 1'b0);
    fb_pulse(32'h100, 8'h05, 1'b1, 1'b0);
    predict(32'h100, INST_BR);
    check("gs_taken", pd_taken, 1'b1);
    pd_valid = 1'b1;
    fb_pulse(32'h900, 8'h10, 1'b1, 1'b1);
    pd_valid = 1'b0;
    check("ghr_restore_wins", pd_hist, 8'h21);
    #1 check("gs_idx_nt", pd_taken, 1'b0);
    pd_valid = 1'b1;
    @(posedge clk);
    #1 pd_valid = 1'b0;
    check("ghr_shift", pd_hist, 8'h42);
`else
    // history is tied off without gshare
    pd_valid = 1'b1;
    fb_pulse(32'h800, 8'hFF, 1'b1, 1'b1);
    pd_valid = 1'b0;
    check("ghr_off", pd_hist, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
